// File: rtl/can_arb_pkg.sv
// rtl/can_arb_pkg.sv - shared types and constants for the CAN transmit arbiter
package can_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } arb_state_e;

  localparam int RETRY_W       = 4;
  localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/can_id_min.sv
// rtl/can_id_min.sv - lowest-identifier winner among pending mailboxes
module can_id_min #(
  parameter int N_MBOX = 4,
  parameter int ID_W   = 11
) (
  input  logic [N_MBOX-1:0]         pend,
  input  logic [N_MBOX*ID_W-1:0]    ids,
  output logic [$clog2(N_MBOX)-1:0] win_idx,
  output logic                      win_valid
);

  localparam int SEL_W = $clog2(N_MBOX);

  logic [ID_W-1:0] best_id;

  // Linear scan; strict less-than keeps the lowest index on equal identifiers
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '0;
    for (int i = 0; i < N_MBOX; i++) begin
      if (pend[i] && (!win_valid || (ids[i*ID_W +: ID_W] < best_id))) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(i);
        best_id   = ids[i*ID_W +: ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_arbiter.sv
// rtl/can_tx_arbiter.sv - transmit mailbox scheduler driving the CAN transmit engine
module can_tx_arbiter
  import can_arb_pkg::*;
#(
  parameter int N_MBOX    = 4,
  parameter int ID_W      = 11,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                      CAN_CLK,
  input  logic                      CAN_RST,
  input  logic [N_MBOX-1:0]         mb_req,
  input  logic [N_MBOX-1:0]         mb_abort,
  input  logic [N_MBOX*ID_W-1:0]    mb_id,
  output logic [N_MBOX-1:0]         mb_pending,
  output logic [N_MBOX-1:0]         mb_done,
  output logic [N_MBOX-1:0]         mb_fail,
  output logic                      tx_start,
  output logic [$clog2(N_MBOX)-1:0] tx_sel,
  output logic [ID_W-1:0]           tx_id,
  output logic                      tx_abort,
  input  logic                      tx_done,
  input  logic                      tx_lost,
  input  logic                      tx_err,
  output logic                      busy
);

  localparam int                 SEL_W = $clog2(N_MBOX);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  arb_state_e         state, state_n;
  logic [N_MBOX-1:0]  pend, pend_n, pend_eff, done_n, fail_n;
  logic [RETRY_W-1:0] retry   [N_MBOX];
  logic [RETRY_W-1:0] retry_n [N_MBOX];
  logic               abort_n;
  logic [SEL_W-1:0]   win_idx;
  logic               win_valid;
  logic               in_tx, result, abort_hit;

  // A mailbox aborted in the arbitration cycle must not win that cycle
  assign pend_eff  = pend & ~mb_abort;
  assign in_tx     = (state == START) || (state == WAIT);
  assign result    = (state == WAIT) && (tx_done || tx_err || tx_lost);
  assign abort_hit = tx_abort || mb_abort[tx_sel];

  assign mb_pending = pend;
  assign tx_start   = (state == START);
  assign busy       = (state != IDLE);

  can_id_min #(
    .N_MBOX (N_MBOX),
    .ID_W   (ID_W)
  ) u_id_min (
    .pend      (pend_eff),
    .ids       (mb_id),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // State register
  always_ff @(posedge CAN_CLK) begin
    if (CAN_RST) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state: one pass through arbitration and start per engine attempt
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|pend) state_n = ARB;
      ARB:     state_n = win_valid ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    if (tx_done || tx_err || tx_lost) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pending, retry, abort and result bookkeeping for the next edge
  always_comb begin
    pend_n  = pend;
    done_n  = '0;
    fail_n  = '0;
    abort_n = tx_abort;
    for (int i = 0; i < N_MBOX; i++) begin
      retry_n[i] = retry[i];
      // Anything but the mailbox on the bus is dropped right away
      if (mb_abort[i] && pend[i] && !(in_tx && (tx_sel == SEL_W'(i)))) begin
        pend_n[i]  = 1'b0;
        retry_n[i] = '0;
        fail_n[i]  = 1'b1;
      end
    end
    if (in_tx && mb_abort[tx_sel]) abort_n = 1'b1;
    if (result) begin
      abort_n = 1'b0;
      if (tx_done) begin
        done_n[tx_sel]  = 1'b1;
        pend_n[tx_sel]  = 1'b0;
        retry_n[tx_sel] = '0;
      end else if (abort_hit || (tx_err && (retry[tx_sel] == MAX_R))) begin
        fail_n[tx_sel]  = 1'b1;
        pend_n[tx_sel]  = 1'b0;
        retry_n[tx_sel] = '0;
      end else if (tx_err) begin
        retry_n[tx_sel] = retry[tx_sel] + 1'b1;
      end
    end
    // New requests land after clears so a completing mailbox can be re-armed
    pend_n = pend_n | (mb_req & ~mb_abort);
  end

  // Datapath registers; selection only moves on the arbitration edge
  always_ff @(posedge CAN_CLK) begin
    if (CAN_RST) begin
      pend     <= '0;
      mb_done  <= '0;
      mb_fail  <= '0;
      tx_abort <= 1'b0;
      tx_sel   <= '0;
      tx_id    <= '0;
      for (int i = 0; i < N_MBOX; i++) retry[i] <= '0;
    end else begin
      pend     <= pend_n;
      mb_done  <= done_n;
      mb_fail  <= fail_n;
      tx_abort <= abort_n;
      for (int i = 0; i < N_MBOX; i++) retry[i] <= retry_n[i];
      if (state == ARB && win_valid) begin
        tx_sel <= win_idx;
        tx_id  <= mb_id[win_idx*ID_W +: ID_W];
      end
    end
  end

endmodule

// File: tb/tb_can_tx_arbiter.sv
// tb/tb_can_tx_arbiter.sv - scoreboard bench for the CAN transmit arbiter
module tb_can_tx_arbiter;

  localparam int N = 4;
  localparam int W = 11;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] id;
  } start_t;

  typedef struct {
    logic [N-1:0] done;
    logic [N-1:0] fail;
  } evt_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] mb_req = '0, mb_abort = '0;
  logic [N*W-1:0] mb_id = '0;
  logic [N-1:0] mb_pending, mb_done, mb_fail;
  logic         tx_start, tx_abort, busy;
  logic         tx_done = 1'b0, tx_lost = 1'b0, tx_err = 1'b0;
  logic [1:0]   tx_sel;
  logic [W-1:0] tx_id;

  int n_cmp = 0;
  int n_err = 0;

  start_t exp_start[$];
  evt_t   exp_evt[$];

  can_tx_arbiter #(.N_MBOX(N), .ID_W(W), .MAX_RETRY(3)) dut (
    .CAN_CLK    (clk),
    .CAN_RST    (rst),
    .mb_req     (mb_req),
    .mb_abort   (mb_abort),
    .mb_id      (mb_id),
    .mb_pending (mb_pending),
    .mb_done    (mb_done),
    .mb_fail    (mb_fail),
    .tx_start   (tx_start),
    .tx_sel     (tx_sel),
    .tx_id      (tx_id),
    .tx_abort   (tx_abort),
    .tx_done    (tx_done),
    .tx_lost    (tx_lost),
    .tx_err     (tx_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_start(input int sel, input int id);
    start_t s;
    s.sel = 2'(sel);
    s.id  = W'(id);
    exp_start.push_back(s);
  endtask

  task automatic push_evt(input logic [N-1:0] d, input logic [N-1:0] f);
    evt_t e;
    e.done = d;
    e.fail = f;
    exp_evt.push_back(e);
  endtask

  task automatic req(input int idx, input int id);
    mb_id[idx*W +: W] = W'(id);
    mb_req[idx] = 1'b1;
    cyc();
    mb_req = '0;
  endtask

  task automatic wait_start(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Called in the START cycle: steps into WAIT and returns one engine result
  task automatic finish_tx(input int kind);
    cyc();
    case (kind)
      0:       tx_done = 1'b1;
      1:       tx_err  = 1'b1;
      default: tx_lost = 1'b1;
    endcase
    cyc();
    tx_done = 1'b0;
    tx_err  = 1'b0;
    tx_lost = 1'b0;
  endtask

  // Scoreboard: every start and every done/fail pulse must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        if (exp_start.size() == 0) check("start_unexpected", 32'(tx_start), 32'd0);
        else begin
          start_t s;
          s = exp_start.pop_front();
          check("start_sel", 32'(tx_sel), 32'(s.sel));
          check("start_id", 32'(tx_id), 32'(s.id));
        end
      end
      if ((mb_done | mb_fail) != '0) begin
        if (exp_evt.size() == 0) check("evt_unexpected", 32'({mb_done, mb_fail}), 32'd0);
        else begin
          evt_t e;
          e = exp_evt.pop_front();
          check("evt_done", 32'(mb_done), 32'(e.done));
          check("evt_fail", 32'(mb_fail), 32'(e.fail));
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_pending", 32'(mb_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_sel", 32'(tx_sel), 32'd0);
    check("rst_tx_id", 32'(tx_id), 32'd0);
    check("rst_tx_abort", 32'(tx_abort), 32'd0);
    check("rst_done_fail", 32'({mb_done, mb_fail}), 32'd0);

    // Single request with exact start latency
    push_start(2, 'h123);
    push_evt(4'b0100, 4'b0000);
    req(2, 'h123);
    check("single_pending", 32'(mb_pending), 32'b0100);
    cyc();
    check("single_no_start_yet", 32'(tx_start), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    cyc();
    check("single_start_latency", 32'(tx_start), 32'd1);
    finish_tx(0);
    check("single_pend_clear", 32'(mb_pending), 32'd0);
    check("single_busy_low", 32'(busy), 32'd0);
    cyc();
    check("single_done_width", 32'(mb_done), 32'd0);

    // Priority and ties: service order 1, 3, 0
    mb_id[0*W +: W] = 11'h300;
    mb_id[1*W +: W] = 11'h100;
    mb_id[3*W +: W] = 11'h100;
    push_start(1, 'h100); push_start(3, 'h100); push_start(0, 'h300);
    push_evt(4'b0010, 4'b0000); push_evt(4'b1000, 4'b0000); push_evt(4'b0001, 4'b0000);
    mb_req = 4'b1011;
    cyc();
    mb_req = '0;
    for (int k = 0; k < 3; k++) begin
      wait_start("prio_start");
      finish_tx(0);
    end
    check("prio_pend_clear", 32'(mb_pending), 32'd0);

    // Lost arbitration, newcomer wins, then mailbox 1 exhausts retries
    push_start(1, 'h100);
    req(1, 'h100);
    wait_start("lost_start");
    finish_tx(2);
    check("lost_still_pending", 32'(mb_pending), 32'b0010);
    push_start(0, 'h050);
    push_evt(4'b0001, 4'b0000);
    req(0, 'h050);
    wait_start("lost_newcomer");
    finish_tx(0);
    for (int k = 0; k < 4; k++) begin
      push_start(1, 'h100);
      if (k == 3) push_evt(4'b0000, 4'b0010);
      wait_start("retry_start");
      finish_tx(1);
    end
    check("retry_pend_clear", 32'(mb_pending), 32'd0);
    repeat (6) cyc();

    // Abort of a queued, non-selected mailbox while another is on the bus
    push_start(0, 'h020);
    push_evt(4'b0000, 4'b1000);
    push_evt(4'b0001, 4'b0000);
    mb_id[0*W +: W] = 11'h020;
    mb_id[3*W +: W] = 11'h200;
    mb_req = 4'b1001;
    cyc();
    mb_req = '0;
    wait_start("qabort_start");
    cyc();
    mb_abort[3] = 1'b1;
    cyc();
    mb_abort = '0;
    check("qabort_pending", 32'(mb_pending), 32'b0001);
    check("qabort_no_tx_abort", 32'(tx_abort), 32'd0);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    repeat (6) cyc();

    // Abort of the active mailbox, ending with err then with done
    for (int k = 0; k < 2; k++) begin
      push_start(2, 'h123);
      if (k == 0) push_evt(4'b0000, 4'b0100);
      else        push_evt(4'b0100, 4'b0000);
      req(2, 'h123);
      wait_start("abort_start");
      cyc();
      mb_abort[2] = 1'b1;
      cyc();
      mb_abort = '0;
      check("abort_tx_abort_set", 32'(tx_abort), 32'd1);
      cyc();
      check("abort_tx_abort_held", 32'(tx_abort), 32'd1);
      if (k == 0) tx_err = 1'b1;
      else        tx_done = 1'b1;
      cyc();
      tx_err = 1'b0;
      tx_done = 1'b0;
      check("abort_tx_abort_clear", 32'(tx_abort), 32'd0);
      repeat (6) cyc();
      check("abort_pend_clear", 32'(mb_pending), 32'd0);
    end

    // Reset while waiting on the engine
    push_start(3, 'h010);
    req(3, 'h010);
    wait_start("reset_start");
    cyc();
    rst = 1'b1;
    cyc();
    check("wrst_pending", 32'(mb_pending), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_tx", 32'({tx_start, tx_abort, tx_sel, tx_id}), 32'd0);
    check("wrst_pulses", 32'({mb_done, mb_fail}), 32'd0);
    rst = 1'b0;
    repeat (6) cyc();

    // Abort and request in the same cycle
    mb_id[1*W +: W] = 11'h111;
    mb_req[1] = 1'b1;
    mb_abort[1] = 1'b1;
    cyc();
    mb_req = '0;
    mb_abort = '0;
    check("abreq_pending", 32'(mb_pending), 32'd0);
    repeat (5) cyc();
    check("abreq_idle", 32'(busy), 32'd0);

    // Request on the completing mailbox in its completion cycle
    push_start(2, 'h123); push_start(2, 'h123);
    push_evt(4'b0100, 4'b0000); push_evt(4'b0100, 4'b0000);
    req(2, 'h123);
    wait_start("rereq_first");
    cyc();
    tx_done = 1'b1;
    mb_req[2] = 1'b1;
    cyc();
    tx_done = 1'b0;
    mb_req = '0;
    check("rereq_pending", 32'(mb_pending), 32'b0100);
    wait_start("rereq_second");
    finish_tx(0);
    check("rereq_pend_clear", 32'(mb_pending), 32'd0);

    repeat (6) cyc();
    check("starts_drained", 32'(exp_start.size()), 32'd0);
    check("events_drained", 32'(exp_evt.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
